det_share_ctrl: RTL and testbench
=================================

Name: det_share_ctrl

Overview:
- Scheduler that time-shares one serial pattern-detector datapath between N independent 1-bit input streams.
- Each cycle it grants at most one requesting channel, round-robin. It shifts that channel's bit into the channel's stored history and compares the history against a programmable pattern.
- Each hit is reported as a tagged match event on a valid/ready output.
- It generalises the single-stream "111" detector to a configurable pattern and several channels, and sits between the serial input ports and the event/statistics logic.

Parameters:
- N, 4: number of input channels (2..8).
- MAXLEN, 8: maximum pattern length in bits; history width per channel.
- CW, 16: width of the total-match counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  N  channel i has a bit on in_bit[i]
- in_bit  input  N  serial data bit per channel
- in_ready  output  N  one-hot grant; a bit is accepted when in_valid[i] & in_ready[i]
- cfg_we  input  1  pattern/length write strobe
- cfg_pat  input  MAXLEN  pattern; bit 0 is the most recent bit
- cfg_len  input  4  pattern length, legal range 1..MAXLEN
- match_valid  output  1  match event pending
- match_ch  output  $clog2(N)  channel that matched
- match_ready  input  1  consumer accepts the event
- match_cnt  output  CW  total matches, saturating

Interface (already decided):
- Single clock, clk.
- Reset is rst: synchronous, active-high.

Behaviour:
- Reset values:
  - All histories 0; all fill counters 0; round-robin pointer 0.
  - match_valid 0, match_ch 0, match_cnt 0, in_ready all 0.
  - Pattern = all ones, len = 3 (the "111" detector).
- rst has priority over every other input, including cfg_we.
- Slot free condition: slot_free = !match_valid | match_ready.
- Grant (combinational, depends on in_valid but not on in_ready):
  - No grant if slot_free = 0 or cfg_we = 1.
  - Otherwise grant the first i with in_valid[i] = 1, searching from the pointer upward with wrap at N.
  - in_ready is 0 for all channels when there is no grant.
- On accept of channel g:
  - hist[g] <= {hist[g][MAXLEN-2:0], in_bit[g]}.
  - fill[g] <= min(fill[g]+1, MAXLEN).
  - Pointer <= (g+1) mod N.
- Match condition: new fill >= len and the new history's low len bits equal the pattern's low len bits.
- Overlapping matches count: for pattern 111, input 1111 gives 2 matches.
- Latency: match_valid rises on the clock edge that accepts the completing bit. The event is visible the cycle after in_valid & in_ready.
- Output handshake:
  - match_valid and match_ch are held stable until match_valid & match_ready.
  - A new match and a drain in the same cycle replace the held event with no bubble.
  - Without a new match, a drain clears match_valid.
- match_cnt increments on each new match event and saturates at 2^CW-1.
- Config write, when cfg_we = 1 and 1 <= cfg_len <= MAXLEN:
  - Latch pattern and length.
  - Clear all histories and fills.
  - No grant that cycle; the pointer is unchanged.
  - A pending match event is kept; match_cnt is unchanged.
- Illegal cfg_len (0 or > MAXLEN): the write is ignored entirely (no update, no clearing), but grants are still blocked that cycle.
- Fill < len means no match, even if the stored bits happen to equal the pattern.
- A channel whose in_valid drops while it is not granted loses nothing; its history is kept.
- Asserting rst mid-stream discards the pending event and all histories immediately.

Decomposition:
- Package det_pkg:
  - MAXLEN default.
  - Channel-id width function.
  - Pattern reset constants (all ones, len 3).
- Sub-module rr_arb:
  - N-way round-robin arbiter with an enable input.
  - Outputs a one-hot grant and a binary index; the pointer updates on grant.
- The top level holds history/fill arrays, the compare logic, the output register and the counter.

Test Plan:
- Reset default, single channel: ch0 drives 1,1,1,1,0,1,1,1 one bit per cycle. Required response: match_valid on bits 3, 4 and 8, all with match_ch=0, and match_cnt=3.
- Fairness, all channels constantly valid with match_ready=1: grants must cycle 0,1,2,3,0,... with each in_ready one-hot. A channel sending 1s must match once every 4 cycles after its 3rd bit.
- Backpressure: match_ready=0 with a pending event. Required response: in_ready all 0, and match_ch held for 5 cycles. Raising match_ready drains the event and grants in that same cycle.
- Reconfiguration: write cfg_pat=8'b0000_0101 with cfg_len=3 mid-stream. Required response: histories cleared; ch2 driving 1,0,1 matches only on the 3rd bit after the write. Writing cfg_len=0 changes nothing.
- Interleaving isolation: ch0 sends 1,1 then ch1 sends 0, then ch0 sends 1. Required response: ch0 matches; ch1 history does not disturb ch0.
- Saturation and reset: run with CW=4 for 20 matches; match_cnt must stay at 15. Then assert rst together with cfg_we and in_valid: every output returns to its reset value.

Source files
------------

// File: rtl/det_pkg.sv
// Shared constants and helpers for the time-shared pattern detector.
package det_pkg;

  localparam int MAXLEN_DEF = 8;

  // Reset pattern is all ones; the top slices this down to MAXLEN bits.
  localparam logic [15:0] PAT_RST = '1;
  localparam logic [3:0]  LEN_RST = 4'd3;

  function automatic int ch_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arb.sv
// N-way round-robin arbiter: grants the first request at or after the pointer.
module rr_arb #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] ptr;

  always_comb begin
    int c;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    c   = 0;
    for (int k = 0; k < N; k++) begin
      c = (int'(ptr) + k) % N;
      if (en && !any && req[c]) begin
        any    = 1'b1;
        idx    = IW'(c);
        gnt[c] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (any) begin
      ptr <= (idx == IW'(N - 1)) ? '0 : idx + IW'(1);
    end
  end

endmodule

// File: rtl/det_share_ctrl.sv
// Time-shares one pattern comparator across N serial streams; each hit
// becomes a tagged event on a valid/ready output and bumps a saturating count.
module det_share_ctrl
  import det_pkg::*;
#(
  parameter int N      = 4,
  parameter int MAXLEN = MAXLEN_DEF,
  parameter int CW     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          in_valid,
  input  logic [N-1:0]          in_bit,
  output logic [N-1:0]          in_ready,
  input  logic                  cfg_we,
  input  logic [MAXLEN-1:0]     cfg_pat,
  input  logic [3:0]            cfg_len,
  output logic                  match_valid,
  output logic [ch_w(N)-1:0]    match_ch,
  input  logic                  match_ready,
  output logic [CW-1:0]         match_cnt
);

  localparam int IW = ch_w(N);

  logic [MAXLEN-1:0] hist [N];
  logic [3:0]        fill [N];
  logic [MAXLEN-1:0] pat;
  logic [3:0]        len;

  logic              slot_free;
  logic              cfg_ok;
  logic              accept;
  logic [N-1:0]      gnt;
  logic [IW-1:0]     g_idx;
  logic [MAXLEN-1:0] new_hist;
  logic [MAXLEN-1:0] len_mask;
  logic [3:0]        new_fill;
  logic              hit;

  assign slot_free = !match_valid || match_ready;
  assign cfg_ok    = cfg_we && (cfg_len != 4'd0) && (cfg_len <= 4'(MAXLEN));

  // Any config strobe, legal or not, blocks grants for that cycle.
  rr_arb #(.N(N), .IW(IW)) u_arb (
    .clk (clk),
    .rst (rst),
    .en  (slot_free && !cfg_we && !rst),
    .req (in_valid),
    .gnt (gnt),
    .idx (g_idx),
    .any (accept)
  );

  assign in_ready = gnt;

  always_comb begin
    new_hist = {hist[g_idx][MAXLEN-2:0], in_bit[g_idx]};
    new_fill = (fill[g_idx] >= 4'(MAXLEN)) ? fill[g_idx] : fill[g_idx] + 4'd1;
    len_mask = ~({MAXLEN{1'b1}} << len);
    hit      = accept && (new_fill >= len) && (((new_hist ^ pat) & len_mask) == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the per-channel history is state the spec defines at reset, so it
      // is cleared here rather than left as an unreset RAM.
      for (int i = 0; i < N; i++) begin
        hist[i] <= '0;
        fill[i] <= '0;
      end
      pat         <= PAT_RST[MAXLEN-1:0];
      len         <= LEN_RST;
      match_valid <= 1'b0;
      match_ch    <= '0;
      match_cnt   <= '0;
    end else begin
      if (cfg_ok) begin
        pat <= cfg_pat;
        len <= cfg_len;
        for (int i = 0; i < N; i++) begin
          hist[i] <= '0;
          fill[i] <= '0;
        end
      end else if (accept) begin
        hist[g_idx] <= new_hist;
        fill[g_idx] <= new_fill;
      end

      // A hit only happens with the slot free, so it never overwrites an
      // undrained event; it may replace one being drained this cycle.
      if (hit) begin
        match_valid <= 1'b1;
        match_ch    <= g_idx;
      end else if (match_ready) begin
        match_valid <= 1'b0;
      end

      if (hit && (match_cnt != '1)) begin
        match_cnt <= match_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_det_share_ctrl.sv
// Directed bench for det_share_ctrl (N=4, MAXLEN=8, CW=4 so saturation is reachable).
module tb_det_share_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in_valid;
  logic [3:0] in_bit;
  logic [3:0] in_ready;
  logic       cfg_we;
  logic [7:0] cfg_pat;
  logic [3:0] cfg_len;
  logic       match_valid;
  logic [1:0] match_ch;
  logic       match_ready;
  logic [3:0] match_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  det_share_ctrl #(.N(4), .MAXLEN(8), .CW(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_bit      (in_bit),
    .in_ready    (in_ready),
    .cfg_we      (cfg_we),
    .cfg_pat     (cfg_pat),
    .cfg_len     (cfg_len),
    .match_valid (match_valid),
    .match_ch    (match_ch),
    .match_ready (match_ready),
    .match_cnt   (match_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = '0; in_bit = '0; cfg_we = 1'b0; match_ready = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Present one cycle of input, check the grant, then check the registered event.
  task automatic send(input string tag, input logic [3:0] v, input logic [3:0] b,
                      input logic [3:0] exp_rdy, input logic exp_mv, input logic [1:0] exp_ch);
    in_valid = v;
    in_bit   = b;
    #1;
    check({tag, ".rdy"}, in_ready, exp_rdy);
    tick();
    check({tag, ".mv"}, match_valid, exp_mv);
    if (exp_mv) check({tag, ".ch"}, match_ch, exp_ch);
  endtask

  initial begin
    logic [7:0] seq1;
    logic [7:0] exp1;
    rst = 1'b1; in_valid = '0; in_bit = '0; cfg_we = 1'b0;
    cfg_pat = '0; cfg_len = '0; match_ready = 1'b1;
    tick(); tick();
    check("rst.mv",  match_valid, 1'b0);
    check("rst.ch",  match_ch,    2'd0);
    check("rst.cnt", match_cnt,   4'd0);
    check("rst.rdy", in_ready,    4'b0000);
    rst = 1'b0;

    // Default 111 detector on ch0: 1,1,1,1,0,1,1,1 hits on bits 3, 4 and 8.
    seq1 = 8'b1110_1111;
    exp1 = 8'b1000_1100;
    for (int i = 0; i < 8; i++)
      send($sformatf("t1.b%0d", i), 4'b0001, {3'b000, seq1[i]}, 4'b0001, exp1[i], 2'd0);
    in_valid = '0;
    check("t1.cnt", match_cnt, 4'd3);

    // Fairness: all valid, only ch0 sends ones; it hits on its 3rd and 4th grant.
    do_reset();
    for (int c = 0; c < 16; c++)
      send($sformatf("t2.c%0d", c), 4'b1111, 4'b0001, 4'b0001 << (c % 4),
           (c % 4 == 0) && (c >= 8), 2'd0);
    in_valid = '0;
    check("t2.cnt", match_cnt, 4'd2);

    // Backpressure: held event blocks all grants, then drain and grant together.
    do_reset();
    match_ready = 1'b0;
    send("t3.b0", 4'b0001, 4'b0001, 4'b0001, 1'b0, 2'd0);
    send("t3.b1", 4'b0001, 4'b0001, 4'b0001, 1'b0, 2'd0);
    send("t3.b2", 4'b0001, 4'b0001, 4'b0001, 1'b1, 2'd0);
    for (int i = 0; i < 5; i++)
      send($sformatf("t3.hold%0d", i), 4'b1111, 4'b0001, 4'b0000, 1'b1, 2'd0);
    match_ready = 1'b1;
    send("t3.drain", 4'b1111, 4'b0001, 4'b0010, 1'b0, 2'd0);
    in_valid = '0;
    check("t3.cnt", match_cnt, 4'd1);

    // Reconfig: ch2 has history 1,0 before writing 101/len3; the write must clear it.
    do_reset();
    send("t4.p0", 4'b0100, 4'b0100, 4'b0100, 1'b0, 2'd0);
    send("t4.p1", 4'b0100, 4'b0000, 4'b0100, 1'b0, 2'd0);
    cfg_we = 1'b1; cfg_pat = 8'b0000_0101; cfg_len = 4'd3;
    send("t4.cfg", 4'b0100, 4'b0100, 4'b0000, 1'b0, 2'd0);
    cfg_we = 1'b0;
    send("t4.b0", 4'b0100, 4'b0100, 4'b0100, 1'b0, 2'd0);
    send("t4.b1", 4'b0100, 4'b0000, 4'b0100, 1'b0, 2'd0);
    send("t4.b2", 4'b0100, 4'b0100, 4'b0100, 1'b1, 2'd2);
    // Illegal length: nothing changes, history 101 (fill 3) survives.
    cfg_we = 1'b1; cfg_pat = 8'b0000_0111; cfg_len = 4'd0;
    send("t4.bad", 4'b0100, 4'b0100, 4'b0000, 1'b0, 2'd0);
    cfg_we = 1'b0;
    send("t4.b3", 4'b0100, 4'b0000, 4'b0100, 1'b0, 2'd0);
    send("t4.b4", 4'b0100, 4'b0100, 4'b0100, 1'b1, 2'd2);
    in_valid = '0;
    check("t4.cnt", match_cnt, 4'd2);

    // Interleaving: ch0 1,1 / ch1 0 / ch0 1 -> ch0 still completes 111.
    do_reset();
    send("t5.a", 4'b0001, 4'b0001, 4'b0001, 1'b0, 2'd0);
    send("t5.b", 4'b0001, 4'b0001, 4'b0001, 1'b0, 2'd0);
    send("t5.c", 4'b0010, 4'b0000, 4'b0010, 1'b0, 2'd0);
    send("t5.d", 4'b0001, 4'b0001, 4'b0001, 1'b1, 2'd0);
    in_valid = '0;

    // Saturation: ch3 streams ones, 22 bits -> 20 hits, counter pinned at 15.
    do_reset();
    for (int i = 0; i < 22; i++)
      send($sformatf("t6.b%0d", i), 4'b1000, 4'b1000, 4'b1000, i >= 2, 2'd3);
    check("t6.sat", match_cnt, 4'd15);

    // Reset wins over cfg_we and in_valid.
    rst = 1'b1; cfg_we = 1'b1; cfg_pat = 8'h00; cfg_len = 4'd5;
    in_valid = 4'b1111; in_bit = 4'b1111; match_ready = 1'b0;
    #1;
    check("t6.rst.rdy0", in_ready, 4'b0000);
    tick();
    check("t6.rst.mv",  match_valid, 1'b0);
    check("t6.rst.ch",  match_ch,    2'd0);
    check("t6.rst.cnt", match_cnt,   4'd0);
    check("t6.rst.rdy", in_ready,    4'b0000);
    rst = 1'b0; cfg_we = 1'b0; match_ready = 1'b1;
    send("t6.d0", 4'b0001, 4'b0001, 4'b0001, 1'b0, 2'd0);
    send("t6.d1", 4'b0001, 4'b0001, 4'b0001, 1'b0, 2'd0);
    send("t6.d2", 4'b0001, 4'b0001, 4'b0001, 1'b1, 2'd0);
    in_valid = '0;
    check("t6.cnt", match_cnt, 4'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
